// File: rtl/noc_buffer_pkg.sv
// ============================================================================
// noc_buffer_pkg: shared defaults and width helper for the router input buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package noc_buffer_pkg;

    localparam int VC_DEPTH_DEFAULT = 8;
    localparam int NUM_VC_DEFAULT   = 4;

    function automatic int clog2_int(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vc_fifo_slice.sv
// ============================================================================
// vc_fifo_slice: one virtual-channel FIFO with pointers, count, flags, accept logic.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vc_fifo_slice
    import noc_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = VC_DEPTH_DEFAULT,
    parameter int AFULL_LEVEL = DEPTH - 1,
    parameter int CNT_W       = clog2_int(DEPTH + 1)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [CNT_W-1:0]      count,
    output logic                  pop,
    output logic                  drop
);

    localparam int PTR_W = clog2_int(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [CNT_W-1:0]      cnt;
    logic                  push;

    assign empty       = (cnt == '0);
    assign full        = (cnt == CNT_W'(DEPTH));
    assign almost_full = (cnt >= CNT_W'(AFULL_LEVEL));
    assign count       = cnt;

    // A full slice still takes a write when the same edge frees a slot.
    assign pop  = rd_req && !empty;
    assign push = wr_req && (!full || pop);
    assign drop = wr_req && full && !pop;

    assign head = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/vc_input_buffer.sv
// ============================================================================
// vc_input_buffer: NUM_VC virtual-channel FIFOs behind one write and one read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vc_input_buffer
    import noc_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_VC      = NUM_VC_DEFAULT,
    parameter int DEPTH       = VC_DEPTH_DEFAULT,
    parameter int AFULL_LEVEL = DEPTH - 1,
    parameter int VC_W        = clog2_int(NUM_VC),
    parameter int CNT_W       = clog2_int(DEPTH + 1)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [VC_W-1:0]         wr_vc,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [VC_W-1:0]         rd_vc,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       almost_full,
    output logic [NUM_VC*CNT_W-1:0] count,
    output logic [NUM_VC-1:0]       credit_out,
    output logic                    overflow_err,
    output logic                    underflow_err
);

    logic [NUM_VC-1:0]     wr_sel;
    logic [NUM_VC-1:0]     rd_sel;
    logic [NUM_VC-1:0]     pop;
    logic [NUM_VC-1:0]     drop;
    logic [DATA_WIDTH-1:0] head [NUM_VC];
    logic                  underflow_hit;

    // Indices beyond NUM_VC-1 match no slice, so they are silently ignored.
    generate
        for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
            assign wr_sel[v] = wr_en && (wr_vc == VC_W'(v));
            assign rd_sel[v] = rd_en && (rd_vc == VC_W'(v));

            vc_fifo_slice #(
                .DATA_WIDTH  (DATA_WIDTH),
                .DEPTH       (DEPTH),
                .AFULL_LEVEL (AFULL_LEVEL),
                .CNT_W       (CNT_W)
            ) u_slice (
                .clk         (clk),
                .rst_n       (rst_n),
                .wr_req      (wr_sel[v]),
                .wr_data     (wr_data),
                .rd_req      (rd_sel[v]),
                .head        (head[v]),
                .empty       (empty[v]),
                .full        (full[v]),
                .almost_full (almost_full[v]),
                .count       (count[v*CNT_W +: CNT_W]),
                .pop         (pop[v]),
                .drop        (drop[v])
            );
        end
    endgenerate

    always_comb begin
        rd_data       = '0;
        rd_valid      = 1'b0;
        underflow_hit = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (rd_vc == VC_W'(v)) begin
                rd_data       = head[v];
                rd_valid      = !empty[v];
                underflow_hit = rd_en && empty[v];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_out    <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            credit_out <= pop;
            if (|drop) begin
                overflow_err <= 1'b1;
            end
            if (underflow_hit) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
